// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Start/done handshake bundle for the bit-serial subtractor.
//   master modport: requester side (drives start/a/b/bin, observes results).
//   slave modport : subtractor side (consumes operands, drives results).
//   Signals:
//     start  request, sampled by the subtractor only while idle
//     a, b   minuend / subtrahend (WIDTH bits), bin borrow-in
//     busy   high while the subtraction is in progress
//     done   one-cycle pulse when diff/bout/zero become valid
//     diff   (a - b - bin) mod 2^WIDTH, bout final borrow, zero diff==0
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor computing a - b - bin, one bit per clock,
//   LSB first, with a single full-subtractor cell and a registered borrow.
//   An operation takes WIDTH RUN cycles followed by a one-cycle DONE.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (aborts any operation)
//     bus  serial_subtractor_if.slave: start/a/b/bin in,
//          busy/done/diff/bout/zero out (all outputs registered)
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             d_bit;
    logic             nb_bit;
    logic [WIDTH:0]   diff_shift;

    // Full-subtractor cell on the current LSBs.
    assign d_bit  = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    assign nb_bit = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);
    // New bit enters at the MSB; after WIDTH shifts the first bit sits at the LSB.
    // Built as a concatenation so WIDTH=1 needs no special case.
    assign diff_shift = {d_bit, diff_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    diff_d   = '0;
                    bout_d   = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d   = diff_shift[WIDTH:1];
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = nb_bit;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bout_d  = nb_bit;
                    zero_d  = (diff_shift[WIDTH:1] == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered copies of the next state so they
        // change on the same edge as the FSM with no output decode logic.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation from an idle DUT; checks latency, busy length and results.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic bin, input int exp_diff, input int exp_bout,
                         input int exp_zero, input bit verbose);
        int busy_cnt;
        int guard;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        bus.bin   = ~bin;
        busy_cnt  = 0;
        guard     = 0;
        while (bus.done !== 1'b1 && guard < 12) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            guard++;
        end
        chk({tag, "_done"}, int'(bus.done), 1);
        chk({tag, "_busylen"}, busy_cnt, WIDTH);
        chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
        chk({tag, "_diff"}, int'(bus.diff), exp_diff);
        chk({tag, "_bout"}, int'(bus.bout), exp_bout);
        chk({tag, "_zero"}, int'(bus.zero), exp_zero);
        @(negedge clk);
        chk({tag, "_done_pulse1"}, int'(bus.done), 0);
        if (verbose)
            $display("op %s: a=%0d b=%0d bin=%0d -> diff=%0h bout=%0d zero=%0d",
                     tag, a, b, bin, bus.diff, bus.bout, bus.zero);
    endtask

    logic [3:0] sa [0:27];
    logic [3:0] sb [0:27];
    logic       sbin [0:27];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);
        chk("rst_bout", int'(bus.bout), 0);
        chk("rst_zero", int'(bus.zero), 0);
        rst = 1'b0;

        // Directed vectors, hand-computed.
        do_op("t9m3",  4'd9, 4'd3, 1'b0, 6,    0, 0, 1'b1);
        do_op("t3m9",  4'd3, 4'd9, 1'b0, 'hA, 1, 0, 1'b1);
        do_op("t0m0b", 4'd0, 4'd0, 1'b1, 'hF, 1, 0, 1'b1);
        do_op("t7m7",  4'd7, 4'd7, 1'b0, 0,    0, 1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_diff", int'(bus.diff), 0);
            chk("hold_bout", int'(bus.bout), 0);
            chk("hold_zero", int'(bus.zero), 1);
            chk("hold_done", int'(bus.done), 0);
        end
        $display("hold: results stable over 10 idle cycles");

        // Start held for 20 cycles with changing operands: accepts at edges 0,6,12,18.
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                chk("stream_busy", int'(bus.busy),
                    (((k - 1) % 6) < 4 && (k - 1) <= 21) ? 1 : 0);
                chk("stream_done", int'(bus.done), (k == 5 || k == 11 || k == 17 || k == 23) ? 1 : 0);
            end
            if (k == 5 || k == 11 || k == 17 || k == 23) begin
                logic [4:0] r;
                r = {1'b0, sa[k-5]} - {1'b0, sb[k-5]} - {4'd0, sbin[k-5]};
                chk("stream_diff", int'(bus.diff), int'(r[3:0]));
                chk("stream_bout", int'(bus.bout), int'(r[4]));
                $display("stream: accept@%0d a=%0d b=%0d bin=%0d -> diff=%0h bout=%0d",
                         k - 5, sa[k-5], sb[k-5], sbin[k-5], bus.diff, bus.bout);
            end
            sa[k]   = 4'((k * 3 + 1) % 16);
            sb[k]   = 4'((k * 5 + 2) % 16);
            sbin[k] = k[0];
            bus.start = (k < 20);
            bus.a     = sa[k];
            bus.b     = sb[k];
            bus.bin   = sbin[k];
        end
        bus.start = 1'b0;

        // Asynchronous reset two cycles into RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd3;
        bus.bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_diff", int'(bus.diff), 0);
        chk("arst_bout", int'(bus.bout), 0);
        chk("arst_zero", int'(bus.zero), 0);
        $display("arst: outputs cleared mid-RUN");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("arst_nodone", int'(bus.done), 0);
            chk("arst_nobusy", int'(bus.busy), 0);
        end
        do_op("t15m1", 4'd15, 4'd1, 1'b0, 14, 0, 0, 1'b1);

        // Exhaustive sweep against 5-bit two's complement arithmetic.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic [4:0] r;
                    r = 5'(ia) - 5'(ib) - 5'(ic);
                    do_op("exh", 4'(ia), 4'(ib), 1'(ic), int'(r[3:0]), int'(r[4]),
                          (r[3:0] == 4'd0) ? 1 : 0, 1'b0);
                end
            end
        end
        $display("exhaustive: 512 operations checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
